// File: rtl/logic_axi4_stream_register_slice_if.sv
// AXI4-Stream interface: handshake plus payload fields, with packed-vector read()/comb_write()
// helpers. Disabled fields (USE_* = 0) are excluded from the packed vector.
interface logic_axi4_stream_if #(
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int USE_TLAST   = 1,
    parameter int USE_TKEEP   = 1,
    parameter int USE_TSTRB   = 1
);
    localparam int TDATA_WIDTH = TDATA_BYTES * 8;
    localparam int TLAST_WIDTH = (USE_TLAST > 0) ? 1 : 0;
    localparam int TKEEP_WIDTH = (USE_TKEEP > 0) ? TDATA_BYTES : 0;
    localparam int TSTRB_WIDTH = (USE_TSTRB > 0) ? TDATA_BYTES : 0;
    localparam int WIDTH = TUSER_WIDTH + TDEST_WIDTH + TID_WIDTH + TLAST_WIDTH
                         + TKEEP_WIDTH + TSTRB_WIDTH + TDATA_WIDTH;

    typedef logic [WIDTH-1:0] packed_t;

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TDATA_BYTES-1:0] tstrb;
    logic [TDATA_BYTES-1:0] tkeep;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TUSER_WIDTH-1:0] tuser;

    // Packed as {tuser, tdest, tid, tlast, tkeep, tstrb, tdata}, MSB first; built by
    // shifting so absent fields never need a zero-width slice.
    function automatic packed_t read();
        packed_t v;
        v = WIDTH'(tuser);
        v = (v << TDEST_WIDTH) | WIDTH'(tdest);
        v = (v << TID_WIDTH) | WIDTH'(tid);
        if (TLAST_WIDTH > 0) v = (v << 1) | WIDTH'(tlast);
        if (TKEEP_WIDTH > 0) v = (v << TDATA_BYTES) | WIDTH'(tkeep);
        if (TSTRB_WIDTH > 0) v = (v << TDATA_BYTES) | WIDTH'(tstrb);
        v = (v << TDATA_WIDTH) | WIDTH'(tdata);
        return v;
    endfunction

    function automatic void comb_write(input packed_t data);
        packed_t v;
        v     = data;
        tstrb = '1;
        tkeep = '1;
        tlast = 1'b1;
        tdata = v[TDATA_WIDTH-1:0];
        v     = v >> TDATA_WIDTH;
        if (TSTRB_WIDTH > 0) begin
            tstrb = v[TDATA_BYTES-1:0];
            v     = v >> TDATA_BYTES;
        end
        if (TKEEP_WIDTH > 0) begin
            tkeep = v[TDATA_BYTES-1:0];
            v     = v >> TDATA_BYTES;
        end
        if (TLAST_WIDTH > 0) begin
            tlast = v[0];
            v     = v >> 1;
        end
        tid   = v[TID_WIDTH-1:0];
        v     = v >> TID_WIDTH;
        tdest = v[TDEST_WIDTH-1:0];
        v     = v >> TDEST_WIDTH;
        tuser = v[TUSER_WIDTH-1:0];
    endfunction

    modport rx (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready,
        import read
    );

    modport tx (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready,
        import comb_write
    );
endinterface

// File: rtl/logic_axi4_stream_register_slice.sv
// AXI4-Stream forward register slice: STAGES registers on tvalid/payload, combinational ready chain.
// Define LOGIC_AXI4_STREAM_REGISTER_SLICE_DATA_RESET_EN to reset payload and zero it on drain.
module logic_axi4_stream_register_slice #(
    parameter int TDATA_BYTES = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int USE_TLAST   = 1,
    parameter int USE_TKEEP   = 1,
    parameter int USE_TSTRB   = 1,
    parameter int STAGES      = 1
) (
    input  logic            aclk,
    input  logic            areset,
    logic_axi4_stream_if.rx rx,
    logic_axi4_stream_if.tx tx
);
    localparam int TDATA_WIDTH = TDATA_BYTES * 8;
    localparam int TLAST_WIDTH = (USE_TLAST > 0) ? 1 : 0;
    localparam int TKEEP_WIDTH = (USE_TKEEP > 0) ? TDATA_BYTES : 0;
    localparam int TSTRB_WIDTH = (USE_TSTRB > 0) ? TDATA_BYTES : 0;
    localparam int WIDTH = TUSER_WIDTH + TDEST_WIDTH + TID_WIDTH + TLAST_WIDTH
                         + TKEEP_WIDTH + TSTRB_WIDTH + TDATA_WIDTH;

    if (STAGES < 0 || STAGES > 16) begin : g_bad_stages
        $error("logic_axi4_stream_register_slice: STAGES=%0d outside 0..16", STAGES);
    end

    if (STAGES == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = aclk ^ areset;

        always_comb begin
            tx.tvalid = rx.tvalid;
            tx.comb_write(rx.read());
            rx.tready = tx.tready;
        end
    end else begin : g_stages
        logic [STAGES-1:0] valid_q;
        logic [STAGES-1:0] valid_in;
        logic [STAGES-1:0] ready_in;
        logic [WIDTH-1:0]  data_q  [STAGES];
        logic [WIDTH-1:0]  data_in [STAGES];

        // Ready is folded from the output back to stage 0 so a stalled tx only
        // blocks stages that actually hold a beat.
        always_comb begin
            logic ready_next;
            valid_in[0] = rx.tvalid;
            data_in[0]  = rx.read();
            for (int unsigned i = 1; i < STAGES; i++) begin
                valid_in[i] = valid_q[i-1];
                data_in[i]  = data_q[i-1];
            end
            ready_next = tx.tready;
            for (int unsigned k = 0; k < STAGES; k++) begin
                ready_next             = !valid_q[STAGES-1-k] || ready_next;
                ready_in[STAGES-1-k]   = ready_next;
            end
        end

        always_ff @(posedge aclk) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                if (areset) begin
                    valid_q[i] <= 1'b0;
                end else if (ready_in[i]) begin
                    valid_q[i] <= valid_in[i];
                end
            end
        end

`ifdef LOGIC_AXI4_STREAM_REGISTER_SLICE_DATA_RESET_EN
        always_ff @(posedge aclk) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                if (areset) begin
                    data_q[i] <= '0;
                end else if (ready_in[i]) begin
                    if (valid_in[i]) begin
                        data_q[i] <= data_in[i];
                    end else if (valid_q[i]) begin
                        data_q[i] <= '0;
                    end
                end
            end
        end
`else
        always_ff @(posedge aclk) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                if (valid_in[i] && ready_in[i]) begin
                    data_q[i] <= data_in[i];
                end
            end
        end
`endif

        assign rx.tready = ready_in[0] && !areset;

        always_comb begin
            tx.tvalid = valid_q[STAGES-1];
            tx.comb_write(data_q[STAGES-1]);
        end
    end
endmodule
